note_tone_gen: RTL and testbench
================================

Name: note_tone_gen

Overview:
- Tone generator that sits directly downstream of the note-period ROM.
- Accepts one note at a time through a valid/ready handshake. Each note is a 16-bit half-period count and a 16-bit duration, both measured in 50 kHz ticks.
- Produces a square-wave AUDIO bit for the duration, then a fixed silent articulation gap, then pulses DONE.
- Feeds the audio output/mixer stage. A sequencer drives the ROM index and presents the ROM output here.

Parameters:
- GAP_TICKS, 250, silent articulation gap after each note, in TICKs (250 = 5 ms at 50 kHz). Legal range 0..65535.
- REST_CODE, 16'hFFFF, PERIOD value meaning "no sound".

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- TICK  input  1  one-CLK-wide 50 kHz enable strobe. All time counting advances only on TICK.
- NOTE_VALID  input  1  upstream has a note on PERIOD/DURATION.
- NOTE_READY  output  1  block can accept a note. Equals 1 only in IDLE.
- PERIOD  input  16  half-period in TICKs (ROM output). REST_CODE or 0 = rest.
- DURATION  input  16  note length in TICKs.
- STOP  input  1  abort the current note immediately.
- AUDIO  output  1  square-wave output.
- BUSY  output  1  high in PLAY or GAP.
- DONE  output  1  one-CLK pulse when a note, including its gap, completes.

Behaviour:
- Reset (CLK edge with RESET=1):
  - State goes to IDLE.
  - AUDIO=0, DONE=0, BUSY=0, NOTE_READY=1 from the first cycle after reset.
  - All counters and captured registers are cleared.
  - RESET mid-note aborts with no DONE.
- Handshake:
  - A note is accepted on the CLK edge where NOTE_VALID && NOTE_READY.
  - PERIOD and DURATION are captured into internal registers on that edge. Later input changes are ignored until the next acceptance.
- Rest detection: rest = (captured PERIOD == REST_CODE) or (captured PERIOD == 0).
- States:
  - IDLE:
    - On accept with DURATION != 0: go to PLAY, clear the half-period counter hcnt and the duration counter dcnt to 0.
    - If not a rest, set AUDIO=1 on the same edge.
    - On accept with DURATION == 0: go to GAP (or DONE directly if GAP_TICKS == 0).
  - PLAY, on each TICK:
    - dcnt increments.
    - If not a rest: hcnt increments. When hcnt reaches PERIOD-1, AUDIO toggles and hcnt returns to 0. Half-period is exactly PERIOD ticks.
    - When dcnt reaches DURATION-1 on a TICK: go to GAP, AUDIO=0, clear the gap counter gcnt.
  - GAP:
    - AUDIO held at 0.
    - On each TICK gcnt increments. When gcnt reaches GAP_TICKS-1, go to DONE.
    - GAP_TICKS == 0: GAP is skipped and PLAY goes straight to DONE.
  - DONE: lasts exactly one CLK. DONE=1, AUDIO=0, then IDLE.
- Latency:
  - First AUDIO rise happens on the accept edge.
  - Total note time is DURATION + GAP_TICKS TICKs.
  - DONE is asserted one CLK after the final counted TICK.
  - NOTE_READY returns to 1 the cycle after DONE.
- Rest notes: AUDIO stays 0 for the whole duration. Timing and DONE are identical to a sounded note.
- PERIOD == 1: AUDIO toggles on every TICK (25 kHz).
- STOP:
  - STOP=1 in PLAY, GAP or DONE: next state is IDLE, AUDIO=0, no DONE pulse.
  - STOP in IDLE has no effect and does not block acceptance.
  - STOP has priority over TICK-driven transitions.
- TICK outside PLAY/GAP is ignored.
- NOTE_VALID while busy is ignored. The note is held upstream because NOTE_READY=0.
- Counters are 16-bit and cannot wrap, because each compare terminates before 2^16.
- All outputs are registered except NOTE_READY and BUSY, which are a pure decode of the state register.

Test Plan:
1. Reset then sounded note, GAP_TICKS=4, TICK every CLK, PERIOD=16'h0039, DURATION=200 -> AUDIO=1 at accept; AUDIO toggles after ticks 57, 114, 171; AUDIO=0 after tick 200; DONE pulses exactly once, 4 ticks later; NOTE_READY=1 on the next cycle.
2. Rest note, PERIOD=16'hFFFF, DURATION=20, GAP_TICKS=4 -> AUDIO=0 throughout; DONE 24 ticks plus 1 CLK after accept; BUSY high for the whole note.
3. Sparse TICK (1 in 8 CLKs), PERIOD=3, DURATION=12, GAP_TICKS=0 -> AUDIO period of 6 ticks (48 CLKs); exactly 2 full cycles; DONE directly after tick 12 with no gap.
4. STOP asserted at tick 50 of a PERIOD=16'h0020, DURATION=100 note -> next cycle IDLE, AUDIO=0, no DONE, NOTE_READY=1; a new note presented immediately is accepted.
5. Edge cases:
   - DURATION=0 with GAP_TICKS=4 -> no AUDIO activity; DONE after 4 ticks.
   - NOTE_VALID held high with a changing PERIOD during PLAY -> the changes are ignored.
   - Back-to-back notes are accepted one cycle after each DONE.
6. RESET asserted in GAP -> next cycle AUDIO=0, BUSY=0, NOTE_READY=1, DONE never pulses.

Source files
------------

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: plays one note (half-period, duration in 50 kHz ticks),
// then a silent articulation gap, then pulses o_done for one clock.
module note_tone_gen #(
  parameter int unsigned GAP_TICKS = 250,
  parameter logic [15:0] REST_CODE = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_tick,
  input  logic        i_note_valid,
  output logic        o_note_ready,
  input  logic [15:0] i_period,
  input  logic [15:0] i_duration,
  input  logic        i_stop,
  output logic        o_audio,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a note transfers on the clock edge where i_note_valid && o_note_ready;
  // o_note_ready is high only in IDLE, so the upstream holds its note while we are busy.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic        GAP_EN   = (GAP_TICKS != 0);
  localparam logic [15:0] GAP_LAST = 16'(GAP_TICKS - 1);

  state_t      r_state;
  logic [15:0] r_period;
  logic [15:0] r_duration;
  logic [15:0] r_hcnt;
  logic [15:0] r_dcnt;
  logic [15:0] r_gcnt;
  logic        r_rest;
  logic        r_audio;
  logic        r_done;

  logic        w_rest_in;
  logic [15:0] w_half_last;
  logic [15:0] w_dur_last;

  assign w_rest_in   = (i_period == REST_CODE) || (i_period == 16'd0);
  assign w_half_last = r_period - 16'd1;
  assign w_dur_last  = r_duration - 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_period   <= 16'd0;
      r_duration <= 16'd0;
      r_hcnt     <= 16'd0;
      r_dcnt     <= 16'd0;
      r_gcnt     <= 16'd0;
      r_rest     <= 1'b0;
      r_audio    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_note_valid) begin
            r_period   <= i_period;
            r_duration <= i_duration;
            r_rest     <= w_rest_in;
            r_hcnt     <= 16'd0;
            r_dcnt     <= 16'd0;
            r_gcnt     <= 16'd0;
            if (i_duration != 16'd0) begin
              r_state <= S_PLAY;
              r_audio <= !w_rest_in;
            end else if (GAP_EN) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            r_audio <= 1'b0;
          end else if (i_tick) begin
            r_dcnt <= r_dcnt + 16'd1;
            if (!r_rest) begin
              if (r_hcnt == w_half_last) begin
                r_hcnt  <= 16'd0;
                r_audio <= !r_audio;
              end else begin
                r_hcnt <= r_hcnt + 16'd1;
              end
            end
            // End of note wins over a toggle landing on the same tick.
            if (r_dcnt == w_dur_last) begin
              r_audio <= 1'b0;
              r_gcnt  <= 16'd0;
              if (GAP_EN) begin
                r_state <= S_GAP;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_GAP: begin
          r_audio <= 1'b0;
          if (i_stop) begin
            r_state <= S_IDLE;
          end else if (i_tick) begin
            if (r_gcnt == GAP_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_gcnt <= r_gcnt + 16'd1;
            end
          end
        end
        S_DONE: begin
          r_audio <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_note_ready = (r_state == S_IDLE);
  assign o_busy       = (r_state == S_PLAY) || (r_state == S_GAP);
  assign o_audio      = r_audio;
  assign o_done       = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: a negedge monitor measures each note (ticks, AUDIO rises,
// AUDIO-high ticks) and compares against a reference model queued when the note is sent.
module tb_note_tone_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        valid;
  logic        stop;
  logic [15:0] period;
  logic [15:0] duration;

  logic        rdy4, aud4, busy4, done4;
  logic        rdy0, aud0, busy0, done0;
  logic [1:0]  st4, st0;

  logic        use_g0;
  logic        m_ready, m_audio, m_busy, m_done;

  int          checks = 0;
  int          errors = 0;
  int          tick_div = 1;
  logic [47:0] exp_q[$];

  always #5 clk = ~clk;

  note_tone_gen #(.GAP_TICKS(4), .REST_CODE(16'hFFFF)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_note_valid(valid),
    .o_note_ready(rdy4), .i_period(period), .i_duration(duration), .i_stop(stop),
    .o_audio(aud4), .o_busy(busy4), .o_done(done4), .o_dbg_state(st4)
  );

  note_tone_gen #(.GAP_TICKS(0), .REST_CODE(16'hFFFF)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_note_valid(valid),
    .o_note_ready(rdy0), .i_period(period), .i_duration(duration), .i_stop(stop),
    .o_audio(aud0), .o_busy(busy0), .o_done(done0), .o_dbg_state(st0)
  );

  assign m_ready = use_g0 ? rdy0  : rdy4;
  assign m_audio = use_g0 ? aud0  : aud4;
  assign m_busy  = use_g0 ? busy0 : busy4;
  assign m_done  = use_g0 ? done0 : done4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: {total ticks, AUDIO rises, ticks spent with AUDIO high}.
  function automatic logic [47:0] model(input int p, input int d, input int gap);
    int rises = 0;
    int hi = 0;
    if (!(p == 0 || p == 65535)) begin
      for (int k = 0; k * p < d; k++) begin
        if (k % 2 == 0) begin
          rises++;
          hi += (d - k * p < p) ? (d - k * p) : p;
        end
      end
    end
    return {16'(d + gap), 16'(rises), 16'(hi)};
  endfunction

  // Tick strobe: one clock in every tick_div clocks.
  initial begin
    int tcnt = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      tcnt = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
      tick = (tcnt == 0);
    end
  end

  // Monitor: values at a negedge describe the preceding posedge; p_* hold pre-edge outputs.
  int   m_ticks, m_rises, m_hi;
  bit   m_active = 1'b0;
  logic p_ready = 1'b1, p_busy = 1'b0, p_audio = 1'b0;

  always @(negedge clk) begin
    logic [47:0] e;
    logic        acc;
    acc = valid && p_ready && !rst;
    if (acc) begin
      m_active = 1'b1;
      m_ticks  = 0;
      m_hi     = 0;
      m_rises  = m_audio ? 1 : 0;
    end else if (m_active) begin
      if (tick && p_busy) begin
        m_ticks++;
        if (p_audio) m_hi++;
      end
      if (m_audio && !p_audio) m_rises++;
    end
    if (m_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(m_done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("note_ticks", 32'(m_ticks), 32'(e[47:32]));
        chk("note_rises", 32'(m_rises), 32'(e[31:16]));
        chk("note_hi_ticks", 32'(m_hi), 32'(e[15:0]));
        chk("done_audio_low", 32'(m_audio), 32'd0);
        chk("done_after_tick", 32'(tick), 32'd1);
      end
      m_active = 1'b0;
    end else if (!m_busy && !acc) begin
      m_active = 1'b0;
    end
    p_ready = m_ready;
    p_busy  = m_busy;
    p_audio = m_audio;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input bit g0);
    use_g0 = g0;
    rst    = 1'b1;
    valid  = 1'b0;
    stop   = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_ready", 32'(m_ready), 32'd1);
    chk("reset_busy", 32'(m_busy), 32'd0);
    chk("reset_audio", 32'(m_audio), 32'd0);
    chk("reset_done", 32'(m_done), 32'd0);
  endtask

  task automatic send_note(input logic [15:0] p, input logic [15:0] d,
                           input bit expect_done, input bit keep_valid);
    int n = 0;
    while (!m_ready && n < 2000) begin
      step();
      n++;
    end
    chk("ready_before_send", 32'(m_ready), 32'd1);
    valid    = 1'b1;
    period   = p;
    duration = d;
    if (expect_done) exp_q.push_back(model(int'(p), int'(d), use_g0 ? 0 : 4));
    step();
    if (!keep_valid) valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!m_done && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(m_done), 32'd1);
    step();
    chk({tag, "_ready_after"}, 32'(m_ready), 32'd1);
    chk({tag, "_done_single"}, 32'(m_done), 32'd0);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    valid    = 1'b0;
    stop     = 1'b0;
    period   = 16'd0;
    duration = 16'd0;
    use_g0   = 1'b0;

    // Sounded note, tick every clock.
    do_reset(1'b0);
    tick_div = 1;
    send_note(16'h0039, 16'd200, 1'b1, 1'b0);
    chk("t1_audio_at_accept", 32'(m_audio), 32'd1);
    chk("t1_busy", 32'(m_busy), 32'd1);
    wait_done("t1");

    // Rest note.
    send_note(16'hFFFF, 16'd20, 1'b1, 1'b0);
    repeat (10) step();
    chk("t2_busy_mid", 32'(m_busy), 32'd1);
    chk("t2_audio_mid", 32'(m_audio), 32'd0);
    wait_done("t2");

    // Sparse ticks, no gap.
    do_reset(1'b1);
    tick_div = 8;
    send_note(16'd3, 16'd12, 1'b1, 1'b0);
    wait_done("t3");

    // STOP at tick 50, then an immediate new note.
    do_reset(1'b0);
    tick_div = 1;
    send_note(16'h0020, 16'd100, 1'b0, 1'b0);
    repeat (49) step();
    chk("t4_busy_before_stop", 32'(m_busy), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t4_stop_ready", 32'(m_ready), 32'd1);
    chk("t4_stop_audio", 32'(m_audio), 32'd0);
    chk("t4_stop_busy", 32'(m_busy), 32'd0);
    chk("t4_stop_done", 32'(m_done), 32'd0);
    send_note(16'h0010, 16'd30, 1'b1, 1'b0);
    chk("t4_reaccept_busy", 32'(m_busy), 32'd1);
    wait_done("t4");

    // Zero duration: gap only.
    send_note(16'h0039, 16'd0, 1'b1, 1'b0);
    chk("t5a_audio", 32'(m_audio), 32'd0);
    chk("t5a_busy", 32'(m_busy), 32'd1);
    wait_done("t5a");

    // Valid held with changing inputs during PLAY.
    send_note(16'd7, 16'd60, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      period   = 16'($urandom_range(1, 100));
      duration = 16'($urandom_range(1, 500));
      step();
    end
    valid = 1'b0;
    wait_done("t5b");

    // Back-to-back notes, the second accepted on the cycle after DONE.
    send_note(16'd5, 16'd20, 1'b1, 1'b0);
    wait_done("t5c1");
    send_note(16'd1, 16'd15, 1'b1, 1'b0);
    chk("t5c2_busy", 32'(m_busy), 32'd1);
    wait_done("t5c2");
    send_note(16'($urandom_range(1, 9)), 16'($urandom_range(10, 40)), 1'b1, 1'b0);
    wait_done("t5d");

    // RESET during GAP.
    send_note(16'd5, 16'd10, 1'b0, 1'b0);
    repeat (12) step();
    chk("t6_in_gap_busy", 32'(m_busy), 32'd1);
    chk("t6_in_gap_audio", 32'(m_audio), 32'd0);
    rst = 1'b1;
    step();
    chk("t6_rst_audio", 32'(m_audio), 32'd0);
    chk("t6_rst_busy", 32'(m_busy), 32'd0);
    chk("t6_rst_ready", 32'(m_ready), 32'd1);
    rst = 1'b0;
    repeat (20) step();
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
